cond_exec_unit: RTL and testbench
=================================

// Module: cond_exec_unit
// PURPOSE
// - Successor to the single-cycle branch-condition checker, placed between decode and execute.
// - Holds the architectural flag register [Z,C,N,V].
// - Evaluates the 4-bit ARM condition for conditional branches.
// - Sequences Thumb-style IT blocks of up to IT_MAX instructions.
// - Reports per instruction whether it executes and whether a branch is taken.
// PARAMETERS
// - IT_MAX   4   max instructions covered by one IT; mask width; range 2..8
// - CNT_W    3   width of it_remaining; must hold IT_MAX
// PORTS
// - clk           in   1        rising-edge clock
// - rst_n         in   1        asynchronous active-low reset
// - flush         in   1        pipeline flush; aborts IT block
// - instr_valid   in   1        one instruction presented this cycle
// - is_bcc        in   1        instruction is conditional branch
// - cond          in   4        branch condition field (used when is_bcc)
// - it_start      in   1        instruction is IT
// - it_firstcond  in   4        IT base condition
// - it_mask       in   IT_MAX   IT mask; lowest set bit marks block end
// - flags_we      in   1        write flags_in into flag register
// - flags_in      in   4        new flags [Z,C,N,V]
// - flags         out  4        flag register
// - out_valid     out  1        registered instr_valid
// - exec_ok       out  1        instruction passes its condition (commit enable)
// - do_branch     out  1        branch taken
// - in_it         out  1        IT block active
// - it_remaining  out  CNT_W    instructions left in IT block
// - it_err        out  1        one-cycle pulse: malformed/illegal IT use
// BEHAVIOUR
// - Reset: flags=0, all other outputs=0, FSM=IDLE. Reset mid-IT discards the block.
// - Condition table, as ARM:
//     0 EQ Z, 1 NE !Z, 2 CS C, 3 CC !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V,
//     8 HI C&!Z, 9 LS !C|Z, A GE N==V, B LT N!=V, C GT !Z&N==V,
//     D LE Z|N!=V, E AL 1, F never 0.
// - Latency: all outputs registered, 1 cycle after the instruction; evaluation uses the flag register (old flags).
// - Flags: flags<=flags_in on flags_we, independent of instr_valid; updated value is visible next cycle.
// - FSM IDLE:
//     - instr_valid & it_start & it_mask!=0 -> ACTIVE.
//     - Latch firstcond, mask; slot k=0.
//     - it_remaining = IT_MAX - index(lowest set bit of it_mask).
//     - The IT instruction itself: exec_ok=1, do_branch=0.
// - FSM ACTIVE: each instr_valid consumes one slot k.
//     - Slot condition: slot0 = firstcond; slot k>=1 = {firstcond[3:1], mask[IT_MAX-k]}.
//     - exec_ok = eval(slot cond); it_remaining decrements.
//     - When it reaches 0 -> IDLE, in_it=0 on the same edge.
// - do_branch = out_valid & is_bcc & exec_ok & eval(cond). Outside IT, exec_ok = 1 for non-IT instructions.
// - Taken branch inside IT -> IDLE; remaining slots dropped.
// - Idle cycles (instr_valid=0): out_valid, exec_ok, do_branch=0; IT state held.
// - it_err pulses (instruction still reports exec_ok=0, do_branch=0):
//     - it_start with mask==0: stays IDLE.
//     - it_start while ACTIVE: slot consumed, IT not restarted.
//     - it_start & is_bcc together.
// - flush has priority over instr_valid.
//     - Next cycle: out_valid, exec_ok, do_branch=0; FSM=IDLE; it_remaining=0.
//     - flags are not affected.
// CONFIGURATION
// - Macro COND_FLAG_FWD_EN:
//     - Defined: when flags_we & instr_valid in the same cycle, evaluation uses flags_in (bypass).
//     - Undefined: evaluation always uses the flag register; the bypass mux is absent.
// TESTING
// - Reset: rst_n low mid-IT -> all outputs 0, flags=0; after release, no IT slot is applied.
// - Plain branch: flags=Z1C0N0V0, is_bcc cond=0 (EQ) -> do_branch=1 next cycle; cond=1 -> 0.
//   Sweep all 16 conditions x 16 flag values against the table.
// - IT sequence: it_firstcond=0 (EQ), it_mask=4'b1010 (ITET), Z=1, then 3 instrs.
//     - Expected exec_ok = 1,0,1; it_remaining = 3,2,1,0.
//     - in_it drops after the 3rd instruction.
// - Early exit: IT with 4 slots, taken branch in slot 1 -> in_it=0; the next instr executes unconditionally.
// - Errors and flush:
//     - it_mask=0 -> it_err=1 and no IT state.
//     - it_start during IT -> it_err=1.
//     - flush mid-block -> in_it=0, it_remaining=0.
// - Flag hazard: flags_we (Z 0->1) with BEQ in the same cycle.
//     - do_branch=0 without COND_FLAG_FWD_EN.
//     - do_branch=1 with COND_FLAG_FWD_EN.

Source files
------------

// File: rtl/cond_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_exec_unit
// Brief    : Flag register, ARM condition evaluation and IT-block sequencing
//            between decode and execute. Optional macro COND_FLAG_FWD_EN
//            bypasses same-cycle flag writes into the evaluation.
// Revision : 1.0 - initial release
// ============================================================================
module cond_exec_unit #(
    parameter int IT_MAX = 4,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              instr_valid,
    input  logic              is_bcc,
    input  logic [3:0]        cond,
    input  logic              it_start,
    input  logic [3:0]        it_firstcond,
    input  logic [IT_MAX-1:0] it_mask,
    input  logic              flags_we,
    input  logic [3:0]        flags_in,
    output logic [3:0]        flags,
    output logic              out_valid,
    output logic              exec_ok,
    output logic              do_branch,
    output logic              in_it,
    output logic [CNT_W-1:0]  it_remaining,
    output logic              it_err
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_flags;
    logic [3:0]          r_firstcond;
    logic [3:0]          w_firstcond_nxt;
    logic [IT_MAX-1:1]   r_mask;
    logic [IT_MAX-1:1]   w_mask_nxt;
    logic [CNT_W-1:0]    r_slot;
    logic [CNT_W-1:0]    w_slot_nxt;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    w_remaining_nxt;
    logic                r_out_valid;
    logic                w_out_valid_nxt;
    logic                r_exec_ok;
    logic                w_exec_ok_nxt;
    logic                r_do_branch;
    logic                w_do_branch_nxt;
    logic                r_it_err;
    logic                w_it_err_nxt;

    logic [3:0]          w_eval_flags;
    logic [CNT_W-1:0]    w_it_len;
    logic                w_slot_bit;
    logic [3:0]          w_slot_cond;
    logic                w_slot_pass;
    logic                w_br_pass;

    // Flag order is [Z,C,N,V].
    function automatic logic eval_cond(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v;
        {z, cy, n, v} = f;
        case (c)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = !z;
            4'h2:    eval_cond = cy;
            4'h3:    eval_cond = !cy;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = !n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = !v;
            4'h8:    eval_cond = cy && !z;
            4'h9:    eval_cond = !cy || z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = !z && (n == v);
            4'hD:    eval_cond = z || (n != v);
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

`ifdef COND_FLAG_FWD_EN
    assign w_eval_flags = (flags_we && instr_valid) ? flags_in : r_flags;
`else
    assign w_eval_flags = r_flags;
`endif

    // Block length is set by the lowest set mask bit.
    always_comb begin
        w_it_len = '0;
        for (int j = IT_MAX - 1; j >= 0; j--) begin
            if (it_mask[j]) w_it_len = CNT_W'(IT_MAX - j);
        end
    end

    always_comb begin
        w_slot_bit = 1'b0;
        for (int j = 1; j < IT_MAX; j++) begin
            if (r_slot == CNT_W'(j)) w_slot_bit = r_mask[IT_MAX-j];
        end
    end

    assign w_slot_cond = (r_slot == '0) ? r_firstcond : {r_firstcond[3:1], w_slot_bit};
    assign w_slot_pass = eval_cond(w_slot_cond, w_eval_flags);
    assign w_br_pass   = eval_cond(cond, w_eval_flags);

    always_comb begin
        w_state_nxt     = r_state;
        w_firstcond_nxt = r_firstcond;
        w_mask_nxt      = r_mask;
        w_slot_nxt      = r_slot;
        w_remaining_nxt = r_remaining;
        w_out_valid_nxt = 1'b0;
        w_exec_ok_nxt   = 1'b0;
        w_do_branch_nxt = 1'b0;
        w_it_err_nxt    = 1'b0;
        if (flush) begin
            w_state_nxt     = ST_IDLE;
            w_slot_nxt      = '0;
            w_remaining_nxt = '0;
        end else if (instr_valid) begin
            w_out_valid_nxt = 1'b1;
            if (r_state == ST_IDLE) begin
                if (it_start) begin
                    if ((it_mask == '0) || is_bcc) begin
                        w_it_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt     = ST_ACTIVE;
                        w_firstcond_nxt = it_firstcond;
                        w_mask_nxt      = it_mask[IT_MAX-1:1];
                        w_slot_nxt      = '0;
                        w_remaining_nxt = w_it_len;
                        w_exec_ok_nxt   = 1'b1;
                    end
                end else begin
                    w_exec_ok_nxt   = 1'b1;
                    w_do_branch_nxt = is_bcc && w_br_pass;
                end
            end else begin
                // Every instruction inside the block uses up a slot, legal or not.
                w_slot_nxt      = r_slot + CNT_W'(1);
                w_remaining_nxt = r_remaining - CNT_W'(1);
                if (it_start) begin
                    w_it_err_nxt = 1'b1;
                end else begin
                    w_exec_ok_nxt   = w_slot_pass;
                    w_do_branch_nxt = is_bcc && w_slot_pass && w_br_pass;
                end
                if (w_do_branch_nxt || (r_remaining == CNT_W'(1))) begin
                    w_state_nxt     = ST_IDLE;
                    w_slot_nxt      = '0;
                    w_remaining_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_firstcond <= '0;
            r_mask      <= '0;
            r_slot      <= '0;
            r_remaining <= '0;
            r_out_valid <= 1'b0;
            r_exec_ok   <= 1'b0;
            r_do_branch <= 1'b0;
            r_it_err    <= 1'b0;
        end else begin
            r_firstcond <= w_firstcond_nxt;
            r_mask      <= w_mask_nxt;
            r_slot      <= w_slot_nxt;
            r_remaining <= w_remaining_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_exec_ok   <= w_exec_ok_nxt;
            r_do_branch <= w_do_branch_nxt;
            r_it_err    <= w_it_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flags <= '0;
        end else if (flags_we) begin
            r_flags <= flags_in;
        end
    end

    assign flags        = r_flags;
    assign out_valid    = r_out_valid;
    assign exec_ok      = r_exec_ok;
    assign do_branch    = r_do_branch;
    assign in_it        = (r_state == ST_ACTIVE);
    assign it_remaining = r_remaining;
    assign it_err       = r_it_err;

endmodule
`default_nettype wire

// File: tb/tb_cond_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cond_exec_unit
// Brief    : Directed self-checking bench for cond_exec_unit (IT_MAX=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cond_exec_unit;

    localparam int IT_MAX = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              instr_valid;
    logic              is_bcc;
    logic [3:0]        cond;
    logic              it_start;
    logic [3:0]        it_firstcond;
    logic [IT_MAX-1:0] it_mask;
    logic              flags_we;
    logic [3:0]        flags_in;
    logic [3:0]        flags;
    logic              out_valid;
    logic              exec_ok;
    logic              do_branch;
    logic              in_it;
    logic [CNT_W-1:0]  it_remaining;
    logic              it_err;

    int n_checks = 0;
    int n_errors = 0;

    cond_exec_unit #(.IT_MAX(IT_MAX), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .instr_valid  (instr_valid),
        .is_bcc       (is_bcc),
        .cond         (cond),
        .it_start     (it_start),
        .it_firstcond (it_firstcond),
        .it_mask      (it_mask),
        .flags_we     (flags_we),
        .flags_in     (flags_in),
        .flags        (flags),
        .out_valid    (out_valid),
        .exec_ok      (exec_ok),
        .do_branch    (do_branch),
        .in_it        (in_it),
        .it_remaining (it_remaining),
        .it_err       (it_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference built from condition pairs: base test, inverted by cond[0].
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic z, cy, n, v, base;
        z = f[3]; cy = f[2]; n = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy & ~z;
            3'd5: base = ~(n ^ v);
            3'd6: base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF) return 1'b0;
        return base ^ c[0];
    endfunction

    task automatic idle_inputs();
        flush = 0; instr_valid = 0; is_bcc = 0; cond = 0;
        it_start = 0; it_firstcond = 0; it_mask = 0;
    endtask

    task automatic apply(input logic bcc, input logic [3:0] cnd, input logic its,
                         input logic [3:0] fc, input logic [3:0] msk, input logic fl);
        instr_valid = 1; is_bcc = bcc; cond = cnd; it_start = its;
        it_firstcond = fc; it_mask = msk; flush = fl;
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic set_flags(input logic [3:0] f);
        flags_we = 1; flags_in = f;
        @(posedge clk); #1;
        flags_we = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; flags_we = 0; flags_in = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_flags", flags, 0);
        check_eq("rst_outs", {out_valid, exec_ok, do_branch, in_it, it_err}, 0);
        check_eq("rst_rem", it_remaining, 0);
        rst_n = 1;
        idle_cycle();

        // Plain branches, Z=1
        set_flags(4'b1000);
        check_eq("flags_wr", flags, 4'b1000);
        apply(1, 4'h0, 0, 0, 0, 0);
        check_eq("beq_valid", out_valid, 1);
        check_eq("beq_exec", exec_ok, 1);
        check_eq("beq_taken", do_branch, 1);
        apply(1, 4'h1, 0, 0, 0, 0);
        check_eq("bne_taken", do_branch, 0);
        idle_cycle();
        check_eq("idle_outs", {out_valid, exec_ok, do_branch}, 0);

        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                apply(1, 4'(c), 0, 0, 0, 0);
                check_eq($sformatf("sweep c=%0h f=%0h", c, f), do_branch, ref_cond(4'(c), 4'(f)));
            end
        end

        // ITET EQ, Z=1
        set_flags(4'b1000);
        apply(0, 0, 1, 4'h0, 4'b1010, 0);
        check_eq("it_exec", exec_ok, 1);
        check_eq("it_nobr", do_branch, 0);
        check_eq("it_in", in_it, 1);
        check_eq("it_rem0", it_remaining, 3);
        apply(0, 0, 0, 0, 0, 0);
        check_eq("it_s0_exec", exec_ok, 1);
        check_eq("it_s0_rem", it_remaining, 2);
        idle_cycle();
        check_eq("it_hold_valid", out_valid, 0);
        check_eq("it_hold_rem", it_remaining, 2);
        check_eq("it_hold_in", in_it, 1);
        apply(0, 0, 0, 0, 0, 0);
        check_eq("it_s1_exec", exec_ok, 0);
        check_eq("it_s1_rem", it_remaining, 1);
        check_eq("it_s1_in", in_it, 1);
        apply(0, 0, 0, 0, 0, 0);
        check_eq("it_s2_exec", exec_ok, 1);
        check_eq("it_s2_rem", it_remaining, 0);
        check_eq("it_s2_in", in_it, 0);

        // Early exit: 4-slot block, taken BEQ in slot 1
        apply(0, 0, 1, 4'h0, 4'b0001, 0);
        check_eq("ee_rem", it_remaining, 4);
        apply(0, 0, 0, 0, 0, 0);
        check_eq("ee_s0", exec_ok, 1);
        apply(1, 4'h0, 0, 0, 0, 0);
        check_eq("ee_taken", do_branch, 1);
        check_eq("ee_in", in_it, 0);
        check_eq("ee_rem0", it_remaining, 0);
        set_flags(4'b0000);
        apply(0, 0, 0, 0, 0, 0);
        check_eq("ee_after_exec", exec_ok, 1);
        check_eq("ee_after_in", in_it, 0);

        // Malformed IT uses
        apply(0, 0, 1, 4'h0, 4'b0000, 0);
        check_eq("err_m0", it_err, 1);
        check_eq("err_m0_exec", exec_ok, 0);
        check_eq("err_m0_in", in_it, 0);
        idle_cycle();
        check_eq("err_pulse", it_err, 0);
        apply(1, 4'hE, 1, 4'h0, 4'b1000, 0);
        check_eq("err_itbcc", it_err, 1);
        check_eq("err_itbcc_br", do_branch, 0);
        check_eq("err_itbcc_in", in_it, 0);
        apply(0, 0, 1, 4'hE, 4'b0001, 0);
        check_eq("err_act_rem", it_remaining, 4);
        apply(0, 0, 1, 4'hE, 4'b0001, 0);
        check_eq("err_act", it_err, 1);
        check_eq("err_act_exec", exec_ok, 0);
        check_eq("err_act_rem2", it_remaining, 3);
        check_eq("err_act_in", in_it, 1);

        // Flush wins over a valid instruction
        apply(1, 4'hE, 0, 0, 0, 1);
        check_eq("fl_outs", {out_valid, exec_ok, do_branch}, 0);
        check_eq("fl_in", in_it, 0);
        check_eq("fl_rem", it_remaining, 0);
        check_eq("fl_flags", flags, 0);

        // Flag hazard: Z 0->1 together with BEQ
        flags_we = 1; flags_in = 4'b1000;
        apply(1, 4'h0, 0, 0, 0, 0);
        flags_we = 0;
`ifdef COND_FLAG_FWD_EN
        check_eq("haz_br", do_branch, 1);
`else
        check_eq("haz_br", do_branch, 0);
`endif
        check_eq("haz_flags", flags, 4'b1000);

        // Reset mid-IT
        apply(0, 0, 1, 4'h0, 4'b0001, 0);
        check_eq("rmid_in", in_it, 1);
        #2 rst_n = 0;
        #1;
        check_eq("rmid_flags", flags, 0);
        check_eq("rmid_outs", {out_valid, exec_ok, do_branch, in_it, it_err}, 0);
        check_eq("rmid_rem", it_remaining, 0);
        @(posedge clk); #1;
        rst_n = 1;
        idle_cycle();
        apply(1, 4'h1, 0, 0, 0, 0);
        check_eq("rpost_exec", exec_ok, 1);
        check_eq("rpost_br", do_branch, 1);
        check_eq("rpost_in", in_it, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
